cmp_sweep_checker: RTL

- Hardware stimulus/response engine for the cascadable magnitude comparators (8-bit bit-cascaded and tree forms).
- Drives every (a,b) operand pair into a comparator DUT and samples its eq/gt outputs after a fixed settle time.
- Checks the outputs against a built-in golden model, counts mismatches and captures the first failing vector.
- Sits beside the comparator in self-test builds and on FPGA bring-up.

---
 rtl/cmp_sweep_checker.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cmp_sweep_checker.sv
// cmp_sweep_checker - exhaustive stimulus/response engine for a magnitude comparator.
//
// Drives every (a,b) operand pair into an external comparator and waits SETTLE idle cycles.
// It then samples the comparator's eq/gt outputs and checks them against a built-in golden
// model. Mismatches are counted in a saturating counter, and the first failing vector of
// each sweep is captured.
//
// Optional feature, selected by the macro CMP_CASCADE_SWEEP_EN:
//   defined   - each (a,b) pair is applied with cascade inputs (e0,g0) = (1,0), (0,1), (0,0)
//   undefined - cascade inputs are held at (e0,g0) = (1,0)
//
// Parameters:
//   WIDTH   operand width
//   SETTLE  idle cycles between applying a vector and sampling the comparator (0 allowed)
//   ERR_W   width of the saturating error counter
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, abort        begin a sweep (IDLE/DONE only) / return to IDLE (any state, wins)
//   a_out, b_out        operands to the comparator
//   e0_out, g0_out      cascade equal-in / greater-in to the comparator
//   eq_in, gt_in        comparator results
//   busy, done, pass    sweep running / sweep finished / finished with no mismatches
//   err_count           mismatches seen, saturating at all-ones
//   fail_a, fail_b      operands of the first mismatch
//   fail_eq, fail_gt    comparator results at the first mismatch

`timescale 1ns / 1ps

module cmp_sweep_checker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             e0_out,
  output logic             g0_out,
  input  logic             eq_in,
  input  logic             gt_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_eq,
  output logic             fail_gt
);

  typedef enum logic [1:0] {StIdle, StWait, StCheck, StDone} state_e;

  // A vector is held for SETTLE+1 cycles: SETTLE cycles in StWait, then one in StCheck where it
  // is sampled. The wait counter therefore loads SETTLE-1, and StWait is skipped for SETTLE=0.
  localparam int unsigned        CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam state_e             ST_ENTER = (SETTLE == 0) ? StCheck : StWait;

  state_e           r_state, w_state;
  logic [WIDTH-1:0] r_a, w_a;
  logic [WIDTH-1:0] r_b, w_b;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [ERR_W-1:0] r_err, w_err;
  logic [WIDTH-1:0] r_fail_a, w_fail_a;
  logic [WIDTH-1:0] r_fail_b, w_fail_b;
  logic             r_fail_eq, w_fail_eq;
  logic             r_fail_gt, w_fail_gt;
  logic             r_fail_seen, w_fail_seen;

  logic             w_e0;
  logic             w_g0;
  logic             w_casc_last;

`ifdef CMP_CASCADE_SWEEP_EN
  // Cascade phase per (a,b): 0 -> (1,0), 1 -> (0,1), 2 -> (0,0).
  logic [1:0] r_casc, w_casc;

  assign w_e0        = (r_casc == 2'd0);
  assign w_g0        = (r_casc == 2'd1);
  assign w_casc_last = (r_casc == 2'd2);
`else
  assign w_e0        = 1'b1;
  assign w_g0        = 1'b0;
  assign w_casc_last = 1'b1;
`endif

  // Golden model, unsigned compare with cascade inputs.
  logic w_ab_eq;
  logic w_ab_gt;
  logic w_exp_eq;
  logic w_exp_gt;
  logic w_mismatch;
  logic w_last;

  assign w_ab_eq    = (r_a == r_b);
  assign w_ab_gt    = (r_a > r_b);
  assign w_exp_eq   = w_ab_eq & w_e0;
  assign w_exp_gt   = w_ab_gt | (w_ab_eq & w_g0);
  assign w_mismatch = (eq_in != w_exp_eq) || (gt_in != w_exp_gt);
  assign w_last     = (&r_a) & (&r_b) & w_casc_last;

  always_comb begin
    w_state     = r_state;
    w_a         = r_a;
    w_b         = r_b;
    w_cnt       = r_cnt;
    w_err       = r_err;
    w_fail_a    = r_fail_a;
    w_fail_b    = r_fail_b;
    w_fail_eq   = r_fail_eq;
    w_fail_gt   = r_fail_gt;
    w_fail_seen = r_fail_seen;
`ifdef CMP_CASCADE_SWEEP_EN
    w_casc      = r_casc;
`endif

    if (abort) begin
      // Abort wins over everything: results and operands are left as they are.
      w_state = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            w_a         = '0;
            w_b         = '0;
            w_err       = '0;
            w_fail_seen = 1'b0;
            w_cnt       = CNT_LOAD;
            w_state     = ST_ENTER;
`ifdef CMP_CASCADE_SWEEP_EN
            w_casc      = '0;
`endif
          end
        end

        StWait: begin
          if (r_cnt == '0) begin
            w_state = StCheck;
          end else begin
            w_cnt = r_cnt - CNT_W'(1);
          end
        end

        StCheck: begin
          if (w_mismatch) begin
            if (r_err != '1) begin
              w_err = r_err + ERR_W'(1);
            end
            if (!r_fail_seen) begin
              w_fail_seen = 1'b1;
              w_fail_a    = r_a;
              w_fail_b    = r_b;
              w_fail_eq   = eq_in;
              w_fail_gt   = gt_in;
            end
          end

          if (w_last) begin
            w_state = StDone;
          end else begin
            w_cnt   = CNT_LOAD;
            w_state = ST_ENTER;
            // b is the inner loop, a the outer; the cascade phase is innermost when enabled.
`ifdef CMP_CASCADE_SWEEP_EN
            if (w_casc_last) begin
              w_casc = '0;
              w_b    = r_b + WIDTH'(1);
              if (&r_b) begin
                w_a = r_a + WIDTH'(1);
              end
            end else begin
              w_casc = r_casc + 2'd1;
            end
`else
            w_b = r_b + WIDTH'(1);
            if (&r_b) begin
              w_a = r_a + WIDTH'(1);
            end
`endif
          end
        end

        default: w_state = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_err       <= '0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_eq   <= 1'b0;
      r_fail_gt   <= 1'b0;
      r_fail_seen <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_a         <= w_a;
      r_b         <= w_b;
      r_cnt       <= w_cnt;
      r_err       <= w_err;
      r_fail_a    <= w_fail_a;
      r_fail_b    <= w_fail_b;
      r_fail_eq   <= w_fail_eq;
      r_fail_gt   <= w_fail_gt;
      r_fail_seen <= w_fail_seen;
    end
  end

`ifdef CMP_CASCADE_SWEEP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_casc <= '0;
    end else begin
      r_casc <= w_casc;
    end
  end
`endif

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign e0_out    = w_e0;
  assign g0_out    = w_g0;
  assign busy      = (r_state == StWait) || (r_state == StCheck);
  assign done      = (r_state == StDone);
  assign pass      = done && (r_err == '0);
  assign err_count = r_err;
  assign fail_a    = r_fail_a;
  assign fail_b    = r_fail_b;
  assign fail_eq   = r_fail_eq;
  assign fail_gt   = r_fail_gt;

endmodule
